// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 constants, transfer size encoding and bridge FSM state types
//
// Purpose: common definitions for axi_sram_bridge and its write channel.
// Ports: none (package).
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] LEN_SINGLE  = 4'd0;
  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } axi_size_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_B
  } w_state_e;

endpackage

// File: rtl/axi_write_chan.sv
// rtl/axi_write_chan.sv - single-beat AXI3 write issue (AW + W) and B collection
//
// Purpose: accepts one write on wr_grant, drives AW and W independently until
// each handshakes, then waits for B and pulses wr_ok the cycle after it.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   wr_grant               capture wr_addr/wr_size/wr_wdata/wr_wstrb (only honoured in W_IDLE)
//   wr_idle                channel is in W_IDLE and can take a grant
//   wr_ok                  one-cycle pulse after the B handshake
//   aw*/w*/bvalid/bready   AXI3 write address, write data and response channels
module axi_write_chan
  import axi_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] WR_ID  = AXI_ID_DATA
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_grant,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [2:0]            wr_size,
  input  logic [DATA_W-1:0]     wr_wdata,
  input  logic [DATA_W/8-1:0]   wr_wstrb,
  output logic                  wr_idle,
  output logic                  wr_ok,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  wr_ok_q, wr_ok_d;
  logic                  aw_hs;
  logic                  w_hs;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    wr_ok_d   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wr_grant) begin
          awaddr_d  = wr_addr;
          awsize_d  = wr_size;
          wdata_d   = wr_wdata;
          wstrb_d   = wr_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W retire independently; whichever is still open keeps its valid up.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          bready_d  = 1'b1;
          w_state_d = W_B;
        end
      end
      W_B: begin
        if (bvalid) begin
          bready_d  = 1'b0;
          wr_ok_d   = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      wr_ok_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      wr_ok_q   <= wr_ok_d;
    end
  end

  assign wr_idle = (w_state_q == W_IDLE);
  assign wr_ok   = wr_ok_q;
  assign awid    = WR_ID;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - SRAM-like fetch and data ports to single-beat AXI3 master
//
// Purpose: turns an instruction read port and a data read/write port into
// len-0 AXI3 transactions, one read and one write outstanding at most.
// Ports:
//   aclk, aresetn                         clock, synchronous active-low reset
//   inst_req/addr, inst_addr_ok/data_ok   fetch request, acceptance, read-data pulse
//   inst_rdata                            last fetched word
//   data_req/wr/size/addr/wdata/wstrb     data request
//   data_addr_ok/data_ok, data_rdata      acceptance, completion pulse, last loaded word
//   ar*/r*, aw*/w*/b*                     AXI3 master channels (burst/lock/cache/prot constant)
module axi_sram_bridge
  import axi_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  r_state_e            r_state_q, r_state_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [2:0]          ar_size_q, ar_size_d;
  logic [3:0]          ar_id_q, ar_id_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_data_ok_q, inst_data_ok_d;
  logic                data_rd_ok_q, data_rd_ok_d;

  logic                w_idle;
  logic                wr_ok;
  logic                data_rd_inflight;
  logic                data_busy;
  logic                rd_grant;
  logic                inst_grant;
  logic                wr_grant;
  logic                unused_rid;

  // Responses are routed by the id latched at grant time, so rid is not needed.
  assign unused_rid = ^rid;

  // One data access at a time, counted until its data_ok cycle has passed.
  // A pending write also blocks data reads, which keeps loads ordered after stores.
  assign data_rd_inflight = (r_state_q != R_IDLE) & (ar_id_q == ID_DATA);
  assign data_busy        = data_rd_inflight | ~w_idle | wr_ok | data_rd_ok_q;

  assign rd_grant   = (r_state_q == R_IDLE) & data_req & ~data_wr & ~data_busy;
  assign inst_grant = (r_state_q == R_IDLE) & inst_req & ~rd_grant;
  assign wr_grant   = data_req & data_wr & ~data_busy;

  always_comb begin
    r_state_d      = r_state_q;
    ar_addr_d      = ar_addr_q;
    ar_size_d      = ar_size_q;
    ar_id_d        = ar_id_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_data_ok_d = 1'b0;
    data_rd_ok_d   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rd_grant) begin
          ar_addr_d = data_addr;
          ar_size_d = {1'b0, data_size};
          ar_id_d   = ID_DATA;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end else if (inst_grant) begin
          ar_addr_d = inst_addr;
          ar_size_d = SIZE_WORD;
          ar_id_d   = ID_INST;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_R;
        end
      end
      R_R: begin
        if (rvalid) begin
          rready_d  = 1'b0;
          r_state_d = R_IDLE;
          if (ar_id_q == ID_DATA) begin
            data_rdata_d = rdata;
            data_rd_ok_d = 1'b1;
          end else begin
            inst_rdata_d   = rdata;
            inst_data_ok_d = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q      <= R_IDLE;
      ar_addr_q      <= '0;
      ar_size_q      <= '0;
      ar_id_q        <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_rd_ok_q   <= 1'b0;
    end else begin
      r_state_q      <= r_state_d;
      ar_addr_q      <= ar_addr_d;
      ar_size_q      <= ar_size_d;
      ar_id_q        <= ar_id_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_rd_ok_q   <= data_rd_ok_d;
    end
  end

  axi_write_chan #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .WR_ID  (ID_DATA)
  ) u_write_chan (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .wr_grant (wr_grant),
    .wr_addr  (data_addr),
    .wr_size  ({1'b0, data_size}),
    .wr_wdata (data_wdata),
    .wr_wstrb (data_wstrb),
    .wr_idle  (w_idle),
    .wr_ok    (wr_ok),
    .awid     (awid),
    .awaddr   (awaddr),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = rd_grant | wr_grant;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_rd_ok_q | wr_ok;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb/tb_axi_sram_bridge.sv - randomized self-checking bench for axi_sram_bridge
module tb_axi_sram_bridge;

  localparam int NCYC = 4000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;

  always #5 aclk = ~aclk;

  axi_sram_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave memory content: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h83C8_0001;
  endfunction

  // Transaction-level model: what has been accepted and not yet completed.
  bit          rd_out, ar_seen, wr_out, aw_seen, w_seen;
  logic [3:0]  rd_id;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [2:0]  rd_size, wr_size;
  logic [3:0]  wr_strb;
  bit          inst_due, data_due;
  logic [31:0] last_inst, last_data;
  int          r_wait, b_wait, rd_age, wr_age;
  bit          inst_pend, data_pend, first_fetch = 1'b1, did_reset;
  int          n_rd, n_wr, n_same;
  int          pr;

  task automatic clear_model();
    rd_out = 0; ar_seen = 0; wr_out = 0; aw_seen = 0; w_seen = 0;
    inst_due = 0; data_due = 0; last_inst = '0; last_data = '0;
    rd_age = 0; wr_age = 0;
  endtask

  task automatic drive(input int cyc);
    logic [31:0] r32;
    aresetn = (cyc >= 3);
    if (!did_reset && cyc > 1500 && rd_out && ar_seen) begin
      aresetn = 1'b0;
      did_reset = 1'b1;
    end
    case ((cyc / 500) % 4)
      0: pr = 100;
      1: pr = 50;
      2: pr = 20;
      default: pr = 80;
    endcase
    if (!inst_pend && $urandom_range(0, 1) == 0) begin
      r32 = $urandom;
      inst_pend = 1'b1;
      inst_addr = first_fetch ? 32'hBFC0_0000 : {r32[31:2], 2'b00};
    end
    inst_req = inst_pend;
    if (!data_pend && $urandom_range(0, 2) == 0) begin
      r32 = $urandom;
      data_pend  = 1'b1;
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = {16'h8000, r32[15:0]} & ~((32'd1 << data_size) - 32'd1);
      data_wdata = $urandom;
      data_wstrb = 4'($urandom);
    end
    data_req = data_pend;
    arready = ($urandom_range(0, 99) < pr);
    awready = ($urandom_range(0, 99) < pr);
    wready  = ($urandom_range(0, 99) < pr);
    rid     = 4'($urandom);
    if (rd_out && ar_seen) begin
      if (r_wait > 0) begin
        r_wait--;
        rvalid = 1'b0;
      end else begin
        rvalid = 1'b1;
        rdata  = mem_word(rd_addr);
      end
    end else begin
      rvalid = ($urandom_range(0, 7) == 0);
      rdata  = $urandom;
    end
    if (wr_out && aw_seen && w_seen) begin
      if (b_wait > 0) begin
        b_wait--;
        bvalid = 1'b0;
      end else begin
        bvalid = 1'b1;
      end
    end else begin
      bvalid = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic evaluate();
    bit dbusy, exp_drd, exp_dwr, exp_inst, aw_now, w_now;
    dbusy    = (rd_out && rd_id == 4'd1) || wr_out || data_due;
    exp_drd  = data_req && !data_wr && !rd_out && !dbusy;
    exp_dwr  = data_req && data_wr && !dbusy;
    exp_inst = inst_req && !rd_out && !exp_drd;

    check_eq("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_inst));
    check_eq("data_addr_ok", 32'(data_addr_ok), 32'(exp_drd || exp_dwr));
    check_eq("inst_data_ok", 32'(inst_data_ok), 32'(inst_due));
    check_eq("data_data_ok", 32'(data_data_ok), 32'(data_due));
    check_eq("inst_rdata", inst_rdata, last_inst);
    check_eq("data_rdata", data_rdata, last_data);
    check_eq("ar_consts", 32'({arlen, arburst, arlock, arcache, arprot}),
             32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
    check_eq("aw_consts", 32'({awlen, awburst, awlock, awcache, awprot, wlast}),
             32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1}));
    check_eq("arvalid", 32'(arvalid), 32'(rd_out && !ar_seen));
    if (rd_out && !ar_seen) begin
      check_eq("araddr", araddr, rd_addr);
      check_eq("arid", 32'(arid), 32'(rd_id));
      check_eq("arsize", 32'(arsize), 32'(rd_size));
    end
    check_eq("rready", 32'(rready), 32'(rd_out && ar_seen));
    check_eq("awvalid", 32'(awvalid), 32'(wr_out && !aw_seen));
    if (wr_out && !aw_seen) begin
      check_eq("awaddr", awaddr, wr_addr);
      check_eq("awsize", 32'(awsize), 32'(wr_size));
      check_eq("awid", 32'(awid), 32'd1);
    end
    check_eq("wvalid", 32'(wvalid), 32'(wr_out && !w_seen));
    if (wr_out && !w_seen) begin
      check_eq("wdata", wdata, wr_data);
      check_eq("wstrb", 32'(wstrb), 32'(wr_strb));
      check_eq("wid", 32'(wid), 32'd1);
    end
    check_eq("bready", 32'(bready), 32'(wr_out && aw_seen && w_seen));
    check_eq("rd_stall", 32'(rd_age > 100), 32'd0);
    check_eq("wr_stall", 32'(wr_age > 150), 32'd0);

    inst_due = 0;
    data_due = 0;
    if (!aresetn) begin
      clear_model();
      return;
    end

    if (rvalid && rready) begin
      check_eq("r_hs_expected", 32'(rd_out && ar_seen), 32'd1);
      if (rd_out && ar_seen) begin
        if (rd_id == 4'd0) begin
          inst_due = 1; last_inst = mem_word(rd_addr);
        end else begin
          data_due = 1; last_data = mem_word(rd_addr);
        end
        rd_out = 0;
        n_rd++;
      end
    end
    if (bvalid && bready) begin
      check_eq("b_hs_expected", 32'(wr_out && aw_seen && w_seen), 32'd1);
      if (wr_out && aw_seen && w_seen) begin
        data_due = 1;
        wr_out = 0;
        n_wr++;
      end
    end
    if (rd_out && !ar_seen && arvalid && arready) begin
      if (rd_id == 4'd1) check_eq("raw_order", 32'(wr_out), 32'd0);
      ar_seen = 1;
      r_wait = $urandom_range(0, 4);
    end
    aw_now = wr_out && !aw_seen && awvalid && awready;
    w_now  = wr_out && !w_seen && wvalid && wready;
    if (aw_now && w_now) n_same++;
    if ((aw_now || w_now) && (aw_seen || aw_now) && (w_seen || w_now)) b_wait = $urandom_range(0, 5);
    if (aw_now) aw_seen = 1;
    if (w_now) w_seen = 1;

    if (exp_drd) begin
      rd_out = 1; ar_seen = 0; rd_id = 4'd1; rd_addr = data_addr; rd_size = {1'b0, data_size};
      data_pend = 0;
    end
    if (exp_inst) begin
      rd_out = 1; ar_seen = 0; rd_id = 4'd0; rd_addr = inst_addr; rd_size = 3'd2;
      inst_pend = 0; first_fetch = 0;
    end
    if (exp_dwr) begin
      wr_out = 1; aw_seen = 0; w_seen = 0;
      wr_addr = data_addr; wr_size = {1'b0, data_size}; wr_data = data_wdata; wr_strb = data_wstrb;
      data_pend = 0;
    end
    rd_age = rd_out ? rd_age + 1 : 0;
    wr_age = wr_out ? wr_age + 1 : 0;
  endtask

  initial begin
    clear_model();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge aclk);
      #1;
      drive(cyc);
      @(negedge aclk);
      evaluate();
    end
    check_eq("reads_done", 32'(n_rd > 100), 32'd1);
    check_eq("writes_done", 32'(n_wr > 50), 32'd1);
    check_eq("aw_w_same_cycle_seen", 32'(n_same > 0), 32'd1);
    check_eq("reset_in_r_r_seen", 32'(did_reset), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_bridge.md
Name: axi_sram_bridge

Overview:
- Sits directly upstream of the AXI master ports of the top-level CPU wrapper. It is the bus interface stage that the core's fetch and memory stages drive.
- Converts two SRAM-like request ports into single-beat AXI3 transactions (len 0):
  - an instruction read port;
  - a data read/write port.
- Allows at most one outstanding read and one outstanding write.
- Tags reads with arid 0 (fetch) or 1 (data); all writes use id 1.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width is DATA_W/8)
ID_INST, 0, arid used for instruction reads
ID_DATA, 1, arid/awid/wid used for data accesses

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
inst_req  in  1  fetch request valid
inst_addr  in  32  fetch byte address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
inst_rdata  out  32  fetched word
data_req  in  1  data request valid
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  data byte address
data_wdata  in  32  write data
data_wstrb  in  4  byte enables
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  one-cycle pulse: read data valid, or write response received
data_rdata  out  32  loaded word
arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address
arready  in  1
rid/rdata/rvalid  in  4/32/1  AXI read data (rresp, rlast ignored)
rready  out  1
awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1
bvalid  in  1  write response (bid, bresp ignored)
bready  out  1
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Reset state (aresetn low at a clock edge):
  - both FSMs go to IDLE;
  - all valid, ready and _ok outputs are 0;
  - inst_rdata, data_rdata and all address/data registers are 0.
  - Reset mid-transaction abandons it silently; no data_ok pulse is produced.
- Read FSM: R_IDLE -> R_AR -> R_R -> R_IDLE.
  - Grant in R_IDLE is combinational. A data read (data_req & ~data_wr) beats inst_req.
  - The grant asserts the matching *_addr_ok in the same cycle. On that edge it latches addr, size and id (data size = data_size; fetch size = 2), then enters R_AR.
  - R_AR: arvalid = 1 and stays stable until arready, then go to R_R.
  - R_R: rready = 1. On rvalid, register rdata into inst_rdata or data_rdata, chosen by the latched id (not rid).
  - The matching *_data_ok pulses exactly 1 cycle after the r handshake. The FSM returns to R_IDLE on the handshake edge.
  - The next grant may occur in the cycle the data_ok pulse is high.
- Write FSM: W_IDLE -> W_REQ -> W_B -> W_IDLE.
  - Grant in W_IDLE when data_req & data_wr.
  - data_addr_ok = 1 that cycle. Latch addr, size, wdata and wstrb.
  - W_REQ: awvalid and wvalid are both raised, with wlast = 1. Track aw_done and w_done independently; each valid drops after its own handshake. Handshakes may complete in either order or in the same cycle.
  - Go to W_B when both are done. W_B: bready = 1.
  - On bvalid, data_data_ok pulses 1 cycle later; the FSM returns to W_IDLE on the handshake edge.
- Data-port acceptance rules:
  - Only one data access is in flight at a time. data_addr_ok is 0 while a data read or a write is outstanding, including the data_ok cycle of the previous access.
  - inst reads may overlap a pending write.
- Hazard: a data read is never issued while a write is pending. Read-after-write ordering is guaranteed by this rule.
- Stability: arvalid, awvalid and wvalid never drop before their ready, and their payload does not change while valid is high.
- Simultaneous events:
  - inst_req with a data read: data is granted, inst_addr_ok = 0, and the fetch retries later.
  - inst_req with a data write: both are granted the same cycle.
- Unexpected responses: rvalid outside R_R and bvalid outside W_B are ignored, since rready and bready are 0 there.

Decomposition:
- Shared package (axi_pkg):
  - AXI constant values: BURST_INCR = 2'b01, LEN_SINGLE = 0;
  - ID_INST and ID_DATA;
  - the size enum;
  - the FSM state typedefs.
- One natural sub-module: axi_write_chan. It holds the W_IDLE/W_REQ/W_B FSM with the aw_done/w_done tracking.
- The read path stays inline.

Test Plan:
- Fetch 0xBFC00000, arready after 2 cycles, rvalid with rdata 0x3C080001 -> arid 0, arsize 2, arlen 0, arburst 01; inst_data_ok pulses 1 cycle after r handshake with inst_rdata 0x3C080001.
- inst_req and data read to 0x80001000 in the same cycle -> data_addr_ok 1, inst_addr_ok 0, arid 1 issued first; fetch granted after the data r handshake.
- Byte write 0x80002003, wstrb 4'b1000, wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds; bready only after both complete; data_data_ok pulses 1 cycle after bvalid.
- Data write pending (bvalid delayed 5 cycles), then data read request -> data_addr_ok 0 until the write's data_ok cycle has passed; an inst fetch during the wait is still granted.
- Assert aresetn low while in R_R, then release -> all valids and readys 0; no data_ok pulse; a new fetch completes normally.
- awready = wready = 1 in the first W_REQ cycle -> both handshakes complete in the same cycle, and the FSM is in W_B the next cycle.
